hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 Parameter STALL_LIMIT, default 16: consecutive stall cycles before the timeout flag sets.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rs_id, rt_id  input  5 each  source registers of the instruction in ID.
REQ-005 uses_rt_id  input  1  ID instruction reads rt as an operand (R-type, store, branch).
REQ-006 branch_id  input  1  ID holds a branch resolved in ID.
REQ-007 branch_taken_id  input  1  branch in ID resolves taken this cycle.
REQ-008 rd_ex, rt_ex  input  5 each  destination and rt of the instruction in EX.
REQ-009 regwrite_ex, memread_ex  input  1 each  EX instruction writes a register / is a load.
REQ-010 rd_mem  input  5  destination of the instruction in MEM; memread_mem  input  1  MEM instruction is a load.
REQ-011 mdu_busy  input  1  multi-cycle multiply/divide unit is occupied.
REQ-012 pc_write, ifid_write  output  1 each  enable PC / IF-ID register update.
REQ-013 ifid_flush, idex_bubble  output  1 each  clear IF-ID / insert NOP into ID-EX.
REQ-014 hazard_state  output  2  registered class: 00 NONE, 01 STALL, 10 FLUSH, 11 TIMEOUT.
REQ-015 stall_count, flush_count  output  32 each  stall-cycle and flush-event counters.
REQ-016 stall_timeout  output  1  sticky flag, set when a stall run reaches STALL_LIMIT.

Function
REQ-017 load_use = memread_ex & rt_ex!=0 & (rt_ex==rs_id | (uses_rt_id & rt_ex==rt_id)).
REQ-018 branch_dep = branch_id & ((regwrite_ex & rd_ex!=0 & rd_ex matches rs_id or rt_id) | (memread_mem & rd_mem!=0 & rd_mem matches rs_id or rt_id)).
REQ-019 stall = load_use | branch_dep | mdu_busy; evaluated combinationally, effective in the same cycle.
REQ-020 While stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
REQ-021 flush = branch_taken_id & !stall; while flush: ifid_flush=1, pc_write=1, ifid_write=1, idex_bubble=0.
REQ-022 Stall has priority over flush; a taken branch during a stall is ignored until operands are valid.
REQ-023 Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-024 State register: NONE, STALL, FLUSH, TIMEOUT; next = TIMEOUT if run counter reaches STALL_LIMIT, else STALL if stall, else FLUSH if flush, else NONE; hazard_state = state register (one-cycle latency).
REQ-025 TIMEOUT exits to NONE/STALL/FLUSH per REQ-024 when stall deasserts; only stall_timeout remains sticky.
REQ-026 Run counter increments each stall cycle, clears on any non-stall cycle, saturates at STALL_LIMIT.
REQ-027 stall_count increments once per stall cycle; flush_count once per flush cycle; both saturate at 32'hFFFF_FFFF, no wrap.
REQ-028 Register 0 never causes a hazard.

Reset
REQ-029 Asynchronous assertion: state=NONE, hazard_state=00, counters=0, run counter=0, stall_timeout=0.
REQ-030 Combinational outputs follow inputs during reset; reset mid-stall discards the run count.

Structure
REQ-031 Shared pipeline_pkg holds hazard_state_t enum and the default STALL_LIMIT constant.
REQ-032 One sub-module, hazard_event_counter (32-bit saturating, enable input), instantiated for stall_count and flush_count.

Verification
REQ-033 memread_ex=1, rt_ex=5, rs_id=5 -> pc_write=0, idex_bubble=1 same cycle; hazard_state=01 next cycle; stall_count=1.
REQ-034 branch_id=1, regwrite_ex=1, rd_ex=8, rt_id=8, uses_rt_id=1, branch_taken_id=1 -> stall, ifid_flush=0; next cycle with dependency removed -> ifid_flush=1, flush_count=1.
REQ-035 memread_ex=1, rt_ex=0, rs_id=0 -> no stall, all enables 1.
REQ-036 mdu_busy held 20 cycles, STALL_LIMIT=16 -> stall_timeout=1 after 16th stall cycle, hazard_state=11, stall_count=20; stays 1 after mdu_busy drops.
REQ-037 rst_n low during a 5-cycle stall -> counters, state, stall_timeout cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard classification and default stall timeout.
package pipeline_pkg;

  localparam int unsigned STALL_LIMIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    HS_NONE    = 2'b00,
    HS_STALL   = 2'b01,
    HS_FLUSH   = 2'b10,
    HS_TIMEOUT = 2'b11
  } hazard_state_t;

  // Register 0 is hardwired, so a match on it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_event_counter.sv
// 32-bit event counter that saturates at all-ones instead of wrapping.
module hazard_event_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: increment on enable unless already saturated.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / branch-operand / MDU stall detection, taken-branch flush control,
// registered hazard class, event counters and a sticky stall-timeout flag.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rt_id,
  input  logic        branch_id,
  input  logic        branch_taken_id,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rt_ex,
  input  logic        regwrite_ex,
  input  logic        memread_ex,
  input  logic [4:0]  rd_mem,
  input  logic        memread_mem,
  input  logic        mdu_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  hazard_state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic        stall_timeout
);

  localparam int unsigned RUN_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

  logic             load_use_s;
  logic             branch_dep_s;
  logic             stall_s;
  logic             flush_s;
  logic             timeout_hit_s;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  hazard_state_t    state_q;
  logic             stall_timeout_q;

  // Hazard detection; a branch resolved in ID needs both operands forwarded-ready.
  always_comb begin
    load_use_s   = memread_ex &&
                   (reg_match(rt_ex, rs_id) || (uses_rt_id && reg_match(rt_ex, rt_id)));
    branch_dep_s = branch_id &&
                   ((regwrite_ex && (reg_match(rd_ex, rs_id) || reg_match(rd_ex, rt_id))) ||
                    (memread_mem && (reg_match(rd_mem, rs_id) || reg_match(rd_mem, rt_id))));
    stall_s      = load_use_s || branch_dep_s || mdu_busy;
    flush_s      = branch_taken_id && !stall_s;
  end

  // Pipeline enables; stall wins over a taken branch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (stall_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (flush_s) begin
      ifid_flush  = 1'b1;
    end else begin
      pc_write    = 1'b1;
    end
  end

  // Consecutive-stall run length, saturating at the limit.
  always_comb begin
    run_d = '0;
    if (stall_s) begin
      if (run_q == RUN_MAX) begin
        run_d = run_q;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      run_d = '0;
    end
    timeout_hit_s = stall_s && (run_d == RUN_MAX);
  end

  // Hazard class FSM with run counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= HS_NONE;
      run_q           <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      run_q           <= run_d;
      stall_timeout_q <= stall_timeout_q | timeout_hit_s;
      if (timeout_hit_s) begin
        state_q <= HS_TIMEOUT;
      end else if (stall_s) begin
        state_q <= HS_STALL;
      end else if (flush_s) begin
        state_q <= HS_FLUSH;
      end else begin
        state_q <= HS_NONE;
      end
    end
  end

  assign hazard_state  = state_q;
  assign stall_timeout = stall_timeout_q;

  hazard_event_counter u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_s),
    .count (stall_count)
  );

  hazard_event_counter u_flush_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_s),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized and directed checking of hazard_detection_unit against a rule-level model.
module tb_hazard_detection_unit;

  localparam int LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs_id = 5'd0, rt_id = 5'd0, rd_ex = 5'd0, rt_ex = 5'd0, rd_mem = 5'd0;
  logic        uses_rt_id = 1'b0, branch_id = 1'b0, branch_taken_id = 1'b0;
  logic        regwrite_ex = 1'b0, memread_ex = 1'b0, memread_mem = 1'b0, mdu_busy = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, stall_timeout;
  logic [1:0]  hazard_state;
  logic [31:0] stall_count, flush_count;

  int total = 0;
  int bad = 0;

  int          m_run;
  logic [1:0]  m_state;
  logic [31:0] m_stalls, m_flushes;
  logic        m_to;

  always #5 clk = ~clk;

  hazard_detection_unit #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .branch_id(branch_id), .branch_taken_id(branch_taken_id), .rd_ex(rd_ex), .rt_ex(rt_ex),
    .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .rd_mem(rd_mem),
    .memread_mem(memread_mem), .mdu_busy(mdu_busy), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .hazard_state(hazard_state), .stall_count(stall_count), .flush_count(flush_count),
    .stall_timeout(stall_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_stall();
    logic lu, bd;
    lu = memread_ex && rt_ex != 5'd0 && (rt_ex == rs_id || (uses_rt_id && rt_ex == rt_id));
    bd = branch_id &&
         ((regwrite_ex && rd_ex != 5'd0 && (rd_ex == rs_id || rd_ex == rt_id)) ||
          (memread_mem && rd_mem != 5'd0 && (rd_mem == rs_id || rd_mem == rt_id)));
    return lu || bd || mdu_busy;
  endfunction

  function automatic logic m_flush();
    return branch_taken_id && !m_stall();
  endfunction

  // Reference model of registered state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_state <= 2'b00; m_stalls <= 32'd0; m_flushes <= 32'd0; m_to <= 1'b0;
    end else begin
      if (m_stall()) begin
        m_run <= (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
        if (m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 32'd1;
        if (m_run + 1 >= LIMIT) begin
          m_state <= 2'b11;
          m_to    <= 1'b1;
        end else begin
          m_state <= 2'b01;
        end
      end else begin
        m_run   <= 0;
        m_state <= m_flush() ? 2'b10 : 2'b00;
        if (m_flush() && m_flushes != 32'hFFFF_FFFF) m_flushes <= m_flushes + 32'd1;
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("pc_write", {31'd0, pc_write}, {31'd0, !m_stall()});
    chk("ifid_write", {31'd0, ifid_write}, {31'd0, !m_stall()});
    chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, m_stall()});
    chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, m_flush()});
    chk("hazard_state", {30'd0, hazard_state}, {30'd0, m_state});
    chk("stall_count", stall_count, m_stalls);
    chk("flush_count", flush_count, m_flushes);
    chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
  end

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; rd_ex = 5'd0; rt_ex = 5'd0; rd_mem = 5'd0;
    uses_rt_id = 1'b0; branch_id = 1'b0; branch_taken_id = 1'b0;
    regwrite_ex = 1'b0; memread_ex = 1'b0; memread_mem = 1'b0; mdu_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_left;
    idle();
    #12;
    chk("reset_state", {30'd0, hazard_state}, 32'd0);
    chk("reset_stall_count", stall_count, 32'd0);
    do_reset();

    // Load-use on rs.
    @(posedge clk); #1;
    memread_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5;
    #2;
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_bubble", {31'd0, idex_bubble}, 32'd1);
    @(posedge clk); #1;
    idle();
    chk("lu_state", {30'd0, hazard_state}, 32'd1);
    chk("lu_stall_count", stall_count, 32'd1);

    // Branch operand dependency with taken branch, then dependency cleared.
    do_reset();
    @(posedge clk); #1;
    branch_id = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd8; rt_id = 5'd8;
    uses_rt_id = 1'b1; branch_taken_id = 1'b1;
    #2;
    chk("br_stall_pc", {31'd0, pc_write}, 32'd0);
    chk("br_stall_flush", {31'd0, ifid_flush}, 32'd0);
    @(posedge clk); #1;
    regwrite_ex = 1'b0;
    #2;
    chk("br_flush", {31'd0, ifid_flush}, 32'd1);
    chk("br_flush_pc", {31'd0, pc_write}, 32'd1);
    @(posedge clk); #1;
    idle();
    chk("br_flush_count", flush_count, 32'd1);
    chk("br_flush_state", {30'd0, hazard_state}, 32'd2);

    // Register 0 never hazards.
    @(posedge clk); #1;
    memread_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0;
    #2;
    chk("r0_pc_write", {31'd0, pc_write}, 32'd1);
    chk("r0_ifid_write", {31'd0, ifid_write}, 32'd1);
    chk("r0_bubble", {31'd0, idex_bubble}, 32'd0);

    // MDU busy for 20 cycles reaches the timeout.
    do_reset();
    @(posedge clk); #1;
    mdu_busy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 15) begin
        chk("to_before", {31'd0, stall_timeout}, 32'd0);
        chk("to_before_state", {30'd0, hazard_state}, 32'd1);
      end
      if (i == 16) begin
        chk("to_at16", {31'd0, stall_timeout}, 32'd1);
        chk("to_state", {30'd0, hazard_state}, 32'd3);
      end
    end
    mdu_busy = 1'b0;
    chk("to_stall_count", stall_count, 32'd20);
    @(posedge clk); #1;
    chk("to_exit_state", {30'd0, hazard_state}, 32'd0);
    chk("to_sticky", {31'd0, stall_timeout}, 32'd1);

    // Asynchronous reset in the middle of a stall run.
    mdu_busy = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_count", stall_count, 32'd25);
    rst_n = 1'b0;
    #1;
    chk("arst_count", stall_count, 32'd0);
    chk("arst_state", {30'd0, hazard_state}, 32'd0);
    chk("arst_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("arst_comb", {31'd0, pc_write}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Randomized traffic with occasional long MDU runs and reset pulses.
    busy_left = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rs_id = 5'($urandom_range(0, 3));
      rt_id = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3));
      rt_ex = 5'($urandom_range(0, 3));
      rd_mem = 5'($urandom_range(0, 3));
      uses_rt_id = 1'($urandom_range(0, 1));
      branch_id = ($urandom_range(0, 2) == 0);
      branch_taken_id = ($urandom_range(0, 2) == 0);
      regwrite_ex = 1'($urandom_range(0, 1));
      memread_ex = ($urandom_range(0, 3) == 0);
      memread_mem = ($urandom_range(0, 3) == 0);
      if (busy_left == 0 && $urandom_range(0, 60) == 0) busy_left = $urandom_range(10, 24);
      mdu_busy = (busy_left > 0) || ($urandom_range(0, 9) == 0);
      if (busy_left > 0) busy_left--;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
